// File: rtl/si_inst_mem.sv
// Instruction memory answering same-cycle fetches, filled by a streaming
// load port; fetches are blocked until a load has completed.
module si_inst_mem #(
  parameter int INST_DW = 32,
  parameter int INST_AW = 32,
  parameter logic [INST_AW-1:0] PC_START = 32'h8000_0000,
  parameter int DEPTH = 1024,
  parameter logic [INST_DW-1:0] NOP = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inst_en_i,
  input  logic [INST_AW-1:0]         inst_addr_i,
  output logic [INST_DW-1:0]         inst_o,
  output logic                       inst_err_o,
  input  logic                       load_start_i,
  input  logic                       load_valid_i,
  input  logic [INST_DW-1:0]         load_data_i,
  input  logic                       load_last_i,
  output logic                       load_ready_o,
  output logic                       mem_ready_o,
  output logic [$clog2(DEPTH):0]     load_count_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    READY
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       wptr_q, wptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                wr_en;
  logic [INST_DW-1:0]  mem [DEPTH];

  logic [INST_AW-1:0]  offset;
  logic                aligned;
  logic                in_range;
  logic [IW-1:0]       index;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    unique case (state_q)
      EMPTY, READY: begin
        if (load_start_i) begin
          state_d = LOAD;
          wptr_d  = '0;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        // a restart discards any beat presented alongside it
        if (load_start_i) begin
          wptr_d = '0;
          cnt_d  = '0;
        end else if (load_valid_i) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + IW'(1);
          cnt_d  = cnt_q + CW'(1);
          if (load_last_i || wptr_q == IW'(DEPTH - 1)) begin
            state_d = READY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      wptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem[wptr_q] <= load_data_i;
    end
  end

  assign offset   = inst_addr_i - PC_START;
  assign aligned  = (inst_addr_i[1:0] == 2'b00);
  assign in_range = (inst_addr_i >= PC_START) &&
                    ((offset >> 2) < INST_AW'(DEPTH));
  assign index    = offset[IW+1:2];

  always_comb begin
    inst_o     = NOP;
    inst_err_o = 1'b0;
    if (state_q == READY && inst_en_i) begin
      if (aligned && in_range) begin
        inst_o = mem[index];
      end else begin
        inst_err_o = 1'b1;
      end
    end
  end

  assign load_ready_o = (state_q == LOAD);
  assign mem_ready_o  = (state_q == READY);
  assign load_count_o = cnt_q;

endmodule

// File: tb/tb_si_inst_mem.sv
// Directed and randomized checks of si_inst_mem against a word-level
// model of load sessions and fetch decoding.
module tb_si_inst_mem;

  localparam int DEPTH = 64;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] PCS = 32'h8000_0000;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst, inst_en_i, inst_err_o;
  logic [31:0] inst_addr_i, inst_o;
  logic load_start_i, load_valid_i, load_last_i;
  logic [31:0] load_data_i;
  logic load_ready_o, mem_ready_o;
  logic [CW-1:0] load_count_o;

  si_inst_mem #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .inst_en_i(inst_en_i), .inst_addr_i(inst_addr_i),
    .inst_o(inst_o), .inst_err_o(inst_err_o),
    .load_start_i(load_start_i), .load_valid_i(load_valid_i),
    .load_data_i(load_data_i), .load_last_i(load_last_i),
    .load_ready_o(load_ready_o), .mem_ready_o(mem_ready_o),
    .load_count_o(load_count_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: an active session appends words; a finished one makes them fetchable
  logic [31:0] mref [DEPTH];
  bit          wr [DEPTH];
  bit          loading = 0;
  bit          ready = 0;
  int          cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit v,
                            input logic [31:0] d, input bit l);
    if (!r) begin
      loading = 0; ready = 0; cnt = 0;
    end else if (loading) begin
      if (s) cnt = 0;
      else if (v) begin
        mref[cnt] = d; wr[cnt] = 1; cnt++;
        if (l || cnt == DEPTH) begin loading = 0; ready = 1; end
      end
    end else if (s) begin
      loading = 1; ready = 0; cnt = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit v,
                     input logic [31:0] d, input bit l);
    rst = r; load_start_i = s; load_valid_i = v;
    load_data_i = d; load_last_i = l;
    @(posedge clk);
    model_edge(r, s, v, d, l);
    #1;
    rst = 1'b1; load_start_i = 0; load_valid_i = 0; load_last_i = 0;
    chk("load_ready", 32'(load_ready_o), 32'(loading));
    chk("mem_ready", 32'(mem_ready_o), 32'(ready));
    chk("load_count", 32'(load_count_o), 32'(cnt));
  endtask

  task automatic fetch(input string tag, input logic [31:0] a,
                       input bit en);
    logic [31:0] ei;
    bit ee, known;
    longint unsigned al;
    @(negedge clk);
    inst_addr_i = a; inst_en_i = en;
    #1;
    ei = NOPW; ee = 0; known = 1;
    al = 64'(a);
    if (ready && en) begin
      if (a[1:0] != 2'b00 || al < 64'(PCS) ||
          ((al - 64'(PCS)) / 4) >= DEPTH) begin
        ee = 1;
      end else if (wr[(al - 64'(PCS)) / 4]) begin
        ei = mref[(al - 64'(PCS)) / 4];
      end else begin
        known = 0;
      end
    end
    if (known) chk({tag, "_inst"}, inst_o, ei);
    chk({tag, "_err"}, 32'(inst_err_o), 32'(ee));
  endtask

  initial begin
    int n, i;
    bit v;
    logic [31:0] a;
    inst_en_i = 0; inst_addr_i = PCS;
    load_data_i = 0;
    for (int k = 0; k < DEPTH; k++) wr[k] = 0;

    cyc(0, 1, 1, 32'h1, 0);
    cyc(0, 0, 0, 0, 0);
    fetch("rst_fetch", PCS, 1);
    chk("rst_inst_const", inst_o, 32'h0000_0013);

    cyc(1, 1, 0, 0, 0);
    fetch("in_load", PCS, 1);
    cyc(1, 0, 1, 32'h0010_0093, 0);
    cyc(1, 0, 1, 32'h0020_0113, 0);
    cyc(1, 0, 1, 32'h0030_0193, 1);
    chk("ld3_count", 32'(load_count_o), 3);
    fetch("ld3_w1", 32'h8000_0004, 1);
    chk("ld3_w1_const", inst_o, 32'h0020_0113);

    fetch("misalign", 32'h8000_0002, 1);
    fetch("past_end", PCS + 32'(4 * DEPTH), 1);
    fetch("below", 32'h7FFF_FFFC, 1);
    fetch("no_en", 32'h8000_0000, 0);

    cyc(1, 1, 0, 0, 0);
    for (int k = 0; k < DEPTH; k++) cyc(1, 0, 1, $urandom, 0);
    chk("full_count", 32'(load_count_o), DEPTH);
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, $urandom, 1);
    fetch("full_last", PCS + 32'(4 * (DEPTH - 1)), 1);
    fetch("full_first", PCS, 1);

    repeat (2) begin
      n = $urandom_range(1, DEPTH - 1);
      cyc(1, 1, 0, 0, 0);
      i = 0;
      while (i < n) begin
        v = 1'($urandom_range(0, 1));
        cyc(1, 0, v, $urandom, v && (i == n - 1));
        if (v) i++;
      end
      for (int k = 0; k < 12; k++) begin
        a = PCS + 32'(4 * $urandom_range(0, DEPTH - 1));
        if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = $urandom;
        fetch("rnd", a, 1'($urandom_range(0, 4) != 0));
      end
    end

    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 32'hAAAA_0001, 0);
    cyc(1, 0, 1, 32'hAAAA_0002, 0);
    cyc(1, 1, 1, 32'hDEAD_BEEF, 0);
    chk("restart_count", 32'(load_count_o), 0);
    cyc(1, 0, 1, 32'h1111_1111, 1);
    fetch("restart_w0", PCS, 1);
    chk("restart_w0_const", inst_o, 32'h1111_1111);
    fetch("restart_w1", PCS + 4, 1);

    cyc(1, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 0, 1, $urandom, 0);
    cyc(0, 1, 1, $urandom, 1);
    chk("midrst_count", 32'(load_count_o), 0);
    fetch("midrst_fetch", PCS, 1);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 32'h2222_2222, 1);
    fetch("reload_w0", PCS, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
